cache_ctrl: RTL and testbench

- Two-way set-associative, write-back, write-allocate cache controller.
- Sits directly upstream of two cache_way data/tag arrays (way0, way1). Drives their write ports and address, and consumes their tag_data/rd_data.
- Accepts single-word CPU loads and stores. On a miss it performs a line writeback (if the victim is dirty) and a line refill over a 128-bit memory handshake.

---
 rtl/cache_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - two-way set-associative write-back, write-allocate cache controller
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int TAG_BITS   = 23,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [31:0]           cpu_addr,
   input  logic [31:0]           cpu_wdata,
   input  logic [3:0]            cpu_byte_en,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_ready,
   output logic [ADDR_WIDTH-1:0] way_addr,
   output logic [1:0]            way_wr_en,
   output logic [LINE_WIDTH-1:0] way_wr_data,
   output logic [TAG_BITS-1:0]   way_wr_tag,
   output logic [3:0]            way_wr_word_en,
   output logic [3:0]            way_wr_byte_en,
   input  logic [TAG_BITS-1:0]   way0_tag,
   input  logic [TAG_BITS-1:0]   way1_tag,
   input  logic [LINE_WIDTH-1:0] way0_data,
   input  logic [LINE_WIDTH-1:0] way1_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);
   localparam int SETS = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

   state_t                state;
   logic                  req_we;
   logic [TAG_BITS-1:0]   req_tag;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic [1:0]            req_word;
   logic [31:0]           req_wdata;
   logic [3:0]            req_be;
   logic [1:0]            valid [SETS];
   logic [1:0]            dirty [SETS];
   logic [SETS-1:0]       lru;
   logic                  victim;
`ifdef CACHE_CTRL_STATS_EN
   logic                  retry;
`endif

   logic                  hit0, hit1, hit, hit_way;
   logic                  miss_way, miss_dirty;
   logic [LINE_WIDTH-1:0] hit_line, miss_line;
   logic [TAG_BITS-1:0]   miss_tag;
   logic                  unused_addr;

   assign unused_addr = ^cpu_addr[1:0];
   assign way_addr    = req_idx;

   always_comb begin
      hit0     = valid[req_idx][0] && (way0_tag == req_tag);
      hit1     = valid[req_idx][1] && (way1_tag == req_tag);
      hit      = hit0 | hit1;
      hit_way  = hit1;
      hit_line = hit1 ? way1_data : way0_data;
      // Fill an empty way before evicting; way0 wins when both are empty.
      if (!valid[req_idx][0])
         miss_way = 1'b0;
      else if (!valid[req_idx][1])
         miss_way = 1'b1;
      else
         miss_way = lru[req_idx];
      miss_dirty = valid[req_idx][miss_way] && dirty[req_idx][miss_way];
      miss_line  = miss_way ? way1_data : way0_data;
      miss_tag   = miss_way ? way1_tag : way0_tag;
   end

   // Array writes are combinational so a refill is visible to the retrying LOOKUP.
   always_comb begin
      way_wr_en      = 2'b00;
      way_wr_data    = {4{req_wdata}};
      way_wr_tag     = req_tag;
      way_wr_word_en = 4'b0001 << req_word;
      way_wr_byte_en = req_be;
      if (state == LOOKUP && hit && req_we) begin
         way_wr_en[hit_way] = 1'b1;
      end else if (state == REFILL && mem_req && mem_ack) begin
         way_wr_en[victim] = 1'b1;
         way_wr_data       = mem_rdata;
         way_wr_word_en    = 4'hF;
         way_wr_byte_en    = 4'hF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         for (int i = 0; i < SETS; i++) begin
            valid[i] <= 2'b00;
            dirty[i] <= 2'b00;
         end
         lru       <= '0;
         victim    <= 1'b0;
         req_we    <= 1'b0;
         req_tag   <= '0;
         req_idx   <= '0;
         req_word  <= '0;
         req_wdata <= '0;
         req_be    <= '0;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef CACHE_CTRL_STATS_EN
         retry      <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
`endif
      end else begin
         cpu_ready <= 1'b0;
         case (state)
            IDLE: begin
               // The CPU still holds cpu_req during the ready pulse; don't re-accept it.
               if (cpu_req && !cpu_ready) begin
                  req_we    <= cpu_we;
                  req_tag   <= cpu_addr[31 -: TAG_BITS];
                  req_idx   <= cpu_addr[4 +: ADDR_WIDTH];
                  req_word  <= cpu_addr[3:2];
                  req_wdata <= cpu_wdata;
                  req_be    <= cpu_byte_en;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
`ifdef CACHE_CTRL_STATS_EN
               retry <= 1'b0;
               if (!retry) begin
                  if (hit) hit_count  <= hit_count + 32'd1;
                  else     miss_count <= miss_count + 32'd1;
               end
`endif
               if (hit) begin
                  cpu_ready     <= 1'b1;
                  lru[req_idx]  <= ~hit_way;
                  if (req_we)
                     dirty[req_idx][hit_way] <= 1'b1;
                  else
                     cpu_rdata <= hit_line[{req_word, 5'd0} +: 32];
                  state <= IDLE;
               end else begin
                  victim  <= miss_way;
                  mem_req <= 1'b1;
                  if (miss_dirty) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= {miss_tag, req_idx, 4'b0000};
                     mem_wdata <= miss_line;
                     state     <= WRITEBACK;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= {req_tag, req_idx, 4'b0000};
                     state     <= REFILL;
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ack) begin
                  mem_req                <= 1'b0;
                  dirty[req_idx][victim] <= 1'b0;
                  state                  <= REFILL;
               end
            end
            REFILL: begin
               // After a writeback mem_req is low for one cycle before the refill starts.
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {req_tag, req_idx, 4'b0000};
               end else if (mem_ack) begin
                  mem_req                <= 1'b0;
                  valid[req_idx][victim] <= 1'b1;
                  dirty[req_idx][victim] <= 1'b0;
`ifdef CACHE_CTRL_STATS_EN
                  retry                  <= 1'b1;
`endif
                  state                  <= LOOKUP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed bench for cache_ctrl against a reference cache/memory model
module tb_cache_ctrl;
   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req, cpu_we;
   logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]   cpu_byte_en;
   logic         cpu_ready;
   logic [4:0]   way_addr;
   logic [1:0]   way_wr_en;
   logic [127:0] way_wr_data;
   logic [22:0]  way_wr_tag;
   logic [3:0]   way_wr_word_en, way_wr_byte_en;
   logic [22:0]  way0_tag, way1_tag;
   logic [127:0] way0_data, way1_data;
   logic         mem_req, mem_we, mem_ack;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
   logic [31:0]  hit_count, miss_count;
`endif

   cache_ctrl dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata),
      .cpu_ready(cpu_ready), .way_addr(way_addr), .way_wr_en(way_wr_en),
      .way_wr_data(way_wr_data), .way_wr_tag(way_wr_tag), .way_wr_word_en(way_wr_word_en),
      .way_wr_byte_en(way_wr_byte_en), .way0_tag(way0_tag), .way1_tag(way1_tag),
      .way0_data(way0_data), .way1_data(way1_data), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_CTRL_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Two cache_way arrays: combinational read, byte-granular write.
   logic [22:0]  w_tag  [2][32];
   logic [127:0] w_data [2][32];
   assign way0_tag  = w_tag[0][way_addr];
   assign way1_tag  = w_tag[1][way_addr];
   assign way0_data = w_data[0][way_addr];
   assign way1_data = w_data[1][way_addr];
   always @(posedge clk) begin
      for (int w = 0; w < 2; w++) begin
         if (way_wr_en[w]) begin
            w_tag[w][way_addr] <= way_wr_tag;
            for (int k = 0; k < 4; k++)
               for (int b = 0; b < 4; b++)
                  if (way_wr_word_en[k] && way_wr_byte_en[b])
                     w_data[w][way_addr][k*32+b*8 +: 8] <= way_wr_data[k*32+b*8 +: 8];
         end
      end
   end

   function automatic logic [127:0] init_line(input logic [31:0] a);
      if (a == 32'h0000_1230)
         return {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
      return {a ^ 32'h3C00_0000, a ^ 32'h2B00_0000, a ^ 32'h1A00_0000, a ^ 32'h0900_0000};
   endfunction

   // Backing memory with a fixed two-cycle response delay.
   logic [127:0] mem [logic [31:0]];
   logic hold_ack = 1'b0;
   function automatic logic [127:0] mem_line(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return init_line(a);
   endfunction
   initial begin
      int wait_cnt = 0;
      mem_ack = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_ack) mem_ack = 1'b0;
         else if (mem_req && !hold_ack && !rst) begin
            if (wait_cnt < 2) wait_cnt++;
            else begin
               wait_cnt = 0;
               mem_ack  = 1'b1;
               if (mem_we) mem[mem_addr] = mem_wdata;
               else        mem_rdata = mem_line(mem_addr);
            end
         end else wait_cnt = 0;
      end
   end

   // Reference model: flat word memory plus per-set tag/valid/dirty/LRU bookkeeping.
   typedef struct {logic we; logic [31:0] addr; logic [127:0] data;} txn_t;
   txn_t         exp_q[$];
   txn_t         seen_q[$];
   logic [31:0]  ref_mem [logic [31:0]];
   logic [22:0]  m_tag [32][2];
   logic         m_val [32][2];
   logic         m_dirty [32][2];
   logic         m_lru [32];
   int           m_hits, m_misses;
   logic         exp_load = 1'b0;
   logic [31:0]  exp_rdata = '0;

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [127:0] l;
      if (ref_mem.exists({a[31:2], 2'b00})) return ref_mem[{a[31:2], 2'b00}];
      l = init_line({a[31:4], 4'b0000});
      return l[a[3:2]*32 +: 32];
   endfunction

   function automatic logic [127:0] ref_line(input logic [31:0] a);
      return {ref_word(a + 12), ref_word(a + 8), ref_word(a + 4), ref_word(a)};
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 32; s++) begin
         m_lru[s] = 1'b0;
         for (int w = 0; w < 2; w++) begin m_val[s][w] = 1'b0; m_dirty[s][w] = 1'b0; end
      end
      m_hits = 0; m_misses = 0; exp_q.delete(); exp_load = 1'b0;
   endtask

   task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be, output logic was_hit);
      int idx, way;
      logic [22:0] tag;
      logic [31:0] w;
      txn_t t;
      idx = int'(a[8:4]); tag = a[31:9]; way = -1;
      for (int i = 0; i < 2; i++) if (m_val[idx][i] && m_tag[idx][i] == tag) way = i;
      was_hit = (way >= 0);
      if (was_hit) m_hits++;
      else begin
         m_misses++;
         way = !m_val[idx][0] ? 0 : !m_val[idx][1] ? 1 : int'(m_lru[idx]);
         if (m_val[idx][way] && m_dirty[idx][way]) begin
            t.we = 1'b1; t.addr = {m_tag[idx][way], a[8:4], 4'b0000}; t.data = ref_line(t.addr);
            exp_q.push_back(t);
         end
         t.we = 1'b0; t.addr = {a[31:4], 4'b0000}; t.data = '0;
         exp_q.push_back(t);
         m_tag[idx][way] = tag; m_val[idx][way] = 1'b1; m_dirty[idx][way] = 1'b0;
      end
      m_lru[idx] = (way == 0);
      exp_load  = !we;
      exp_rdata = ref_word(a);
      if (we) begin
         m_dirty[idx][way] = 1'b1;
         w = ref_word(a);
         for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
         ref_mem[{a[31:2], 2'b00}] = w;
      end
   endtask

   // Compare process: memory requests, their stability, load data and way-write sanity.
   initial begin
      logic prev_req = 1'b0;
      txn_t cap, t;
      forever begin
         @(negedge clk);
         if (rst) prev_req = 1'b0;
         else begin
            check("way_wr_both", {127'd0, way_wr_en == 2'b11}, 128'd0);
            if (mem_req && !prev_req) begin
               cap.we = mem_we; cap.addr = mem_addr; cap.data = mem_wdata;
               seen_q.push_back(cap);
               if (exp_q.size() == 0) check("mem_unexpected_req", {96'd0, mem_addr}, 128'd0);
               else begin
                  t = exp_q.pop_front();
                  check("mem_we", {127'd0, mem_we}, {127'd0, t.we});
                  check("mem_addr", {96'd0, mem_addr}, {96'd0, t.addr});
                  if (t.we) check("mem_wdata", mem_wdata, t.data);
               end
            end else if (mem_req) begin
               check("mem_stable", {95'd0, mem_we, mem_addr}, {95'd0, cap.we, cap.addr});
               if (cap.we) check("mem_wdata_stable", mem_wdata, cap.data);
            end
            if (cpu_ready && exp_load) check("cpu_rdata", {96'd0, cpu_rdata}, {96'd0, exp_rdata});
            prev_req = mem_req;
         end
      end
   end

   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd);
      logic h;
      int cyc;
      model_access(we, a, wd, be, h);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_byte_en = be;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!cpu_ready && cyc < 300);
      rd = cpu_rdata;
      cpu_req = 1'b0;
      check("ready_seen", {127'd0, cpu_ready}, 128'd1);
      if (h) check("hit_latency", cyc, 2);
      @(posedge clk); #1;
      check("ready_pulse", {127'd0, cpu_ready}, 128'd0);
      check("mem_txns_done", exp_q.size(), 0);
`ifdef CACHE_CTRL_STATS_EN
      check("hit_count", {96'd0, hit_count}, m_hits);
      check("miss_count", {96'd0, miss_count}, m_misses);
`endif
   endtask

   task automatic check_seen(input string name, input int i, input logic we, input logic [31:0] a);
      check({name, "_count"}, {127'd0, seen_q.size() > i}, 128'd1);
      if (seen_q.size() > i) begin
         check({name, "_we"}, {127'd0, seen_q[i].we}, {127'd0, we});
         check({name, "_addr"}, {96'd0, seen_q[i].addr}, {96'd0, a});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [31:0] rd;
      int cyc;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byte_en = '0;
      do_reset();
      check("rst_cpu_ready", {127'd0, cpu_ready}, 128'd0);
      check("rst_cpu_rdata", {96'd0, cpu_rdata}, 128'd0);
      check("rst_mem_req", {127'd0, mem_req}, 128'd0);
      check("rst_mem_we", {127'd0, mem_we}, 128'd0);
      check("rst_mem_addr", {96'd0, mem_addr}, 128'd0);
      check("rst_mem_wdata", mem_wdata, 128'd0);
      check("rst_way_wr_en", {126'd0, way_wr_en}, 128'd0);

      // Cold load, repeat hit, byte store and read-back.
      seen_q.delete();
      access(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd);
      check("lit_cold_load", {96'd0, rd}, {96'd0, 32'hDEAD_BEEF});
      check_seen("lit_cold_refill", 0, 1'b0, 32'h0000_1230);
      check("lit_cold_no_wb", seen_q.size(), 1);
      seen_q.delete();
      access(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd);
      check("lit_hit_no_mem", seen_q.size(), 0);
      access(1'b1, 32'h0000_1234, 32'h0000_00A5, 4'b0001, rd);
      access(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd);
      check("lit_store_load", {96'd0, rd}, {96'd0, 32'hDEAD_BEA5});

      // Second way fills, then dirty way0 is evicted.
      access(1'b0, 32'h0000_0030, 32'h0, 4'h0, rd);
      seen_q.delete();
      access(1'b0, 32'h0000_2030, 32'h0, 4'h0, rd);
      check_seen("lit_wb_1230", 0, 1'b1, 32'h0000_1230);
      if (seen_q.size() > 0) check("lit_wb_word1", {96'd0, seen_q[0].data[63:32]}, {96'd0, 32'hDEAD_BEA5});
      check_seen("lit_rf_2030", 1, 1'b0, 32'h0000_2030);

      // Reset in the middle of a refill.
      hold_ack = 1'b1;
      model_access(1'b0, 32'h0000_4030, 32'h0, 4'h0, rd[0]);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_4030;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!(mem_req && !mem_we) && cyc < 50);
      check("rst_refill_seen", {127'd0, mem_req}, 128'd1);
      rst = 1'b1; cpu_req = 1'b0;
      @(posedge clk); #1;
      check("rst_drops_mem_req", {127'd0, mem_req}, 128'd0);
      check("rst_drops_ready", {127'd0, cpu_ready}, 128'd0);
      check("rst_way_quiet", {126'd0, way_wr_en}, 128'd0);
      rst = 1'b0; hold_ack = 1'b0;
      model_reset();
      seen_q.delete();
      access(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd);
      check_seen("lit_post_rst_miss", 0, 1'b0, 32'h0000_1230);
      access(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd);
      access(1'b0, 32'h0000_1234, 32'h0, 4'h0, rd);
`ifdef CACHE_CTRL_STATS_EN
      check("lit_hit_count", {96'd0, hit_count}, 128'd2);
      check("lit_miss_count", {96'd0, miss_count}, 128'd1);
`endif

      // LRU picks dirty way1 after way0 was touched.
      do_reset();
      access(1'b0, 32'h0000_0030, 32'h0, 4'h0, rd);
      access(1'b1, 32'h0000_2030, 32'h1234_5678, 4'hF, rd);
      access(1'b0, 32'h0000_0030, 32'h0, 4'h0, rd);
      seen_q.delete();
      access(1'b0, 32'h0000_4030, 32'h0, 4'h0, rd);
      check_seen("lit_lru_wb", 0, 1'b1, 32'h0000_2030);
      check_seen("lit_lru_rf", 1, 1'b0, 32'h0000_4030);
      access(1'b0, 32'h0000_2030, 32'h0, 4'h0, rd);
      check("lit_wb_roundtrip", {96'd0, rd}, {96'd0, 32'h1234_5678});

      // Other words, partial byte enables, store misses and double eviction in set 0.
      access(1'b1, 32'h0000_100C, 32'h1111_2222, 4'b1010, rd);
      access(1'b0, 32'h0000_100C, 32'h0, 4'h0, rd);
      access(1'b0, 32'h0000_1008, 32'h0, 4'h0, rd);
      access(1'b1, 32'h0000_300C, 32'hCAFE_F00D, 4'hF, rd);
      access(1'b1, 32'h0000_3004, 32'h0055_0000, 4'b0100, rd);
      access(1'b0, 32'h0000_500C, 32'h0, 4'h0, rd);
      access(1'b0, 32'h0000_100C, 32'h0, 4'h0, rd);
      access(1'b0, 32'h0000_3004, 32'h0, 4'h0, rd);
      access(1'b0, 32'h0000_300C, 32'h0, 4'h0, rd);
      check("lit_store_miss_word", {96'd0, rd}, {96'd0, 32'hCAFE_F00D});

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end
endmodule
